// File: rtl/mini16_s2m_collector.sv
// Round-robin drain of the PE s2m FIFOs into the master's s2m receive memory.
// Each popped {addr, data} item becomes one write, tagged with its source core.
module mini16_s2m_collector #(
    parameter int CORES     = 4,
    parameter int WIDTH_D   = 16,
    parameter int DEPTH_V_F = 16,
    parameter int DEPTH_S2M = 8,
    parameter int MAX_BURST = 4,
    parameter int WIDTH_CNT = 16,
    localparam int CI = (CORES > 1) ? $clog2(CORES) : 1,
    localparam int IW = WIDTH_D + DEPTH_V_F
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [CORES-1:0]      fifo_req_r,
    input  logic [CORES-1:0]      fifo_valid,
    input  logic [CORES*IW-1:0]   fifo_r_data,
    output logic [DEPTH_S2M-1:0]  w_addr,
    output logic [WIDTH_D-1:0]    w_data,
    output logic [CI-1:0]         w_core,
    output logic                  we,
    input  logic                  w_ready,
    output logic                  busy,
    output logic [WIDTH_CNT-1:0]  item_count
);

    // state | meaning
    // IDLE  | polling stopped, all strobes low
    // REQ   | pop request to core r_cur for this one cycle
    // WAIT  | pop response cycle, capture item if fifo_valid[r_cur]
    // WRITE | write strobe held until w_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [1:0]           r_state;
    logic [1:0]           w_nxt_state;
    logic [CI-1:0]        r_cur;
    logic [CI-1:0]        w_nxt_cur;
    logic [CI-1:0]        w_cur_adv;
    logic [BW-1:0]        r_burst;
    logic [BW-1:0]        w_nxt_burst;
    logic [CORES-1:0]     r_req;
    logic [CORES-1:0]     w_req_onehot;
    logic                 r_we;
    logic                 r_busy;
    logic [DEPTH_S2M-1:0] r_addr;
    logic [WIDTH_D-1:0]   r_data;
    logic [CI-1:0]        r_core;
    logic [WIDTH_CNT-1:0] r_count;
    logic [IW-1:0]        w_item;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_unused_item;

    assign w_item    = fifo_r_data[r_cur*IW +: IW];
    // upper address bits are bank select and intentionally dropped
    assign w_unused_item = ^w_item;
    assign w_hit     = (r_state == S_WAIT) && fifo_valid[r_cur];
    assign w_accept  = (r_state == S_WRITE) && w_ready;
    assign w_cur_adv = (r_cur == CI'(CORES - 1)) ? '0 : r_cur + CI'(1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur;
        w_nxt_burst = r_burst;
        case (r_state)
            S_IDLE: begin
                if (enable) w_nxt_state = S_REQ;
            end
            S_REQ: begin
                w_nxt_state = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_valid[r_cur]) begin
                    w_nxt_state = S_WRITE;
                end else begin
                    w_nxt_cur   = w_cur_adv;
                    w_nxt_burst = '0;
                    w_nxt_state = enable ? S_REQ : S_IDLE;
                end
            end
            S_WRITE: begin
                if (w_ready) begin
                    if ((int'(r_burst) + 1 < MAX_BURST) && enable) begin
                        w_nxt_burst = r_burst + BW'(1);
                        w_nxt_state = S_REQ;
                    end else begin
                        w_nxt_cur   = w_cur_adv;
                        w_nxt_burst = '0;
                        w_nxt_state = enable ? S_REQ : S_IDLE;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_onehot = '0;
        if (w_nxt_state == S_REQ) w_req_onehot[w_nxt_cur] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_burst <= '0;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_core  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cur   <= w_nxt_cur;
            r_burst <= w_nxt_burst;
            r_req   <= w_req_onehot;
            r_we    <= (w_nxt_state == S_WRITE);
            r_busy  <= (w_nxt_state != S_IDLE);
            if (w_hit) begin
                r_addr <= w_item[WIDTH_D +: DEPTH_S2M];
                r_data <= w_item[WIDTH_D-1:0];
                r_core <= r_cur;
            end
            if (w_accept) r_count <= r_count + WIDTH_CNT'(1);
        end
    end

    assign fifo_req_r = r_req;
    assign we         = r_we;
    assign busy       = r_busy;
    assign w_addr     = r_addr;
    assign w_data     = r_data;
    assign w_core     = r_core;
    assign item_count = r_count;

endmodule

// File: doc/mini16_s2m_collector.md
# mini16_s2m_collector

Master-side drain engine for the slave-to-master (s2m) FIFOs of a mini16 PE array. It polls each PE's s2m FIFO round-robin, pops `{address, data}` items, and replays them as write strobes into the master's s2m receive memory. The write port is tagged with the source core index and held until the memory side accepts it. It is the reader end of the PE's `fifo_req_r` / `fifo_valid` / `fifo_r_data` port.

## Interface
Parameters:
- `CORES`, 4: number of PEs polled; any value ≥ 1, not required to be a power of two.
- `WIDTH_D`, 16: data width of a FIFO item.
- `DEPTH_V_F`, 16: address width of a FIFO item.
- `DEPTH_S2M`, 8: address width presented on the write port; the item address is truncated to its low bits.
- `MAX_BURST`, 4: maximum items popped from one core before moving to the next (≥ 1).
- `WIDTH_CNT`, 16: width of the delivered-item counter.

Ports (`CI` = max(1, clog2(`CORES`)); `IW` = `WIDTH_D`+`DEPTH_V_F`):
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  polling enable.
- `fifo_req_r`  out  `CORES`  per-core pop request, one-hot or zero.
- `fifo_valid`  in  `CORES`  per-core pop-data valid.
- `fifo_r_data`  in  `CORES`*`IW`  flattened items; core k occupies bits [k*IW +: IW], item = {addr[DEPTH_V_F-1:0], data[WIDTH_D-1:0]}.
- `w_addr`  out  `DEPTH_S2M`  item address low bits.
- `w_data`  out  `WIDTH_D`  item data.
- `w_core`  out  `CI`  source core index.
- `we`  out  1  write strobe.
- `w_ready`  in  1  memory accepts the write in the current cycle.
- `busy`  out  1  state ≠ IDLE.
- `item_count`  out  `WIDTH_CNT`  items delivered; wraps.

## Operation
FIFO contract:
- `req_r` high in cycle N on a non-empty FIFO pops one item.
- `valid` and `data_r` are presented in cycle N+1.
- `valid` stays low in N+1 if the FIFO was empty.

State machine (`cur` = current core, `burst` = items taken from `cur`):
- IDLE: all strobes low. Go to REQ when `enable` = 1.
- REQ: `fifo_req_r` = 1<<`cur` for exactly this cycle. Always go to WAIT.
- WAIT: if `fifo_valid[cur]` = 1, register {addr, data} and `cur` into the `w_*` outputs, then go to WRITE. Otherwise advance, then go to REQ if `enable` = 1, else IDLE.
- WRITE: `we` = 1 with stable `w_addr`/`w_data`/`w_core`. Stay in WRITE while `w_ready` = 0. When `w_ready` = 1:
  - `item_count` += 1.
  - `burst` += 1.
  - If `burst`+1 < `MAX_BURST` and `enable` = 1, stay on `cur` and go to REQ.
  - Otherwise advance, then go to REQ if `enable` = 1, else IDLE.
- Advance: `cur` = (`cur` = `CORES`-1) ? 0 : `cur`+1; `burst` = 0.

Rules:
- A popped item is never dropped. Deassertion of `enable` takes effect only at WAIT-miss or WRITE-accept; an item already in flight completes.
- `fifo_valid` bits for cores other than `cur` are ignored.
- `fifo_valid[cur]` seen outside WAIT is ignored; the FIFO contract makes it impossible.
- `w_addr` = item addr[`DEPTH_S2M`-1:0]. Upper address bits are discarded; they carry bank-select and are not checked.
- All outputs are registered.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE, `cur` = 0, `burst` = 0; `fifo_req_r`, `we`, `w_addr`, `w_data`, `w_core`, `busy`, `item_count` all 0.
- Item cost with `w_ready` tied high: REQ at N, WAIT at N+1, `we` high at N+2, next REQ at N+3. That is 3 cycles per item.
- Empty core costs 2 cycles (REQ, WAIT).
- Worst-case service gap for any core: `CORES`*3*`MAX_BURST` cycles while `w_ready` is held high.
- `we` holds for every cycle that `w_ready` = 0; `w_*` outputs stay constant during the hold.
- Reset asserted mid-WRITE: `we` drops immediately. The pending item is lost; this is accepted because the PE FIFOs reset together with the collector.
- `item_count` wraps from 2^`WIDTH_CNT`-1 to 0.

## Test plan
- `CORES`=4, all FIFOs empty, `enable`=1 → `fifo_req_r` cycles 0001, 0010, 0100, 1000, 0001…, one REQ every 2 cycles; `we` never asserted.
- Core 2 holds 6 items with addr 0x0110+i and data 0xA000+i, `MAX_BURST`=4 → four writes `w_core`=2, `w_addr`=0x10..0x13, then cores 3, 0, 1 polled, then the remaining two writes; `item_count`=6.
- `w_ready` held low for 5 cycles on the first write → `we` high for 6 cycles with constant `w_data`; `item_count` increments once.
- `enable` dropped in the cycle `fifo_req_r`=0010 is asserted, item present → the item is still written, then state IDLE, `busy`=0, no further `fifo_req_r`.
- `CORES`=3, wrap check → `cur` sequence 0, 1, 2, 0; `w_core` never equals 3.
- `reset_n` pulsed low mid-WRITE → all outputs 0 asynchronously; after release the first `fifo_req_r` = 001.
